tcdm_resp_router: RTL

Response-side companion to the round-robin arbitration tree in the TCDM interconnect. It sits between the arbiter root and one memory bank. On the request path it forwards the arbitrated request and throttles grants when too many reads are in flight. It records the winning master index of every accepted transaction in an in-order FIFO. When the bank returns a response, it pops that index and steers the response back to the originating master as a one-hot valid with broadcast data.

---
 rtl/tcdm_resp_router_pkg.sv | 13 +
 rtl/tcdm_idx_fifo.sv | 69 ++++++
 rtl/tcdm_resp_router.sv | 96 +++++++++
 3 files changed

// File: rtl/tcdm_resp_router_pkg.sv
// rtl/tcdm_resp_router_pkg.sv - shared TCDM width helpers used by the arbiter tree and response router
package tcdm_resp_router_pkg;

    // Index width never collapses to zero, even for a single master.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tcdm_idx_fifo.sv
// rtl/tcdm_idx_fifo.sv - in-order index FIFO with fall-through head, any depth >= 1
module tcdm_idx_fifo
    import tcdm_resp_router_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2,
    parameter int unsigned CntW  = cnt_width(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = idx_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tcdm_resp_router.sv
// rtl/tcdm_resp_router.sv - grant throttling and in-order response steering for one TCDM bank
module tcdm_resp_router
    import tcdm_resp_router_pkg::*;
#(
    parameter int unsigned NumReq    = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxOut    = 4,
    parameter logic        RegResp   = 1'b0,
    localparam int unsigned IdxW     = idx_width(NumReq),
    localparam int unsigned CntW     = cnt_width(MaxOut)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 arb_req_i,
    input  logic [IdxW-1:0]      arb_idx_i,
    output logic                 arb_gnt_o,
    output logic                 bank_req_o,
    input  logic                 bank_gnt_i,
    input  logic                 bank_rvalid_i,
    input  logic [DataWidth-1:0] bank_rdata_i,
    output logic [NumReq-1:0]    rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [CntW-1:0]      outstanding_o,
    output logic                 err_o
);

    logic            full, empty, push, pop;
    logic [IdxW-1:0] head_idx;
    logic [NumReq-1:0] rvalid_c;
    logic            err_q, err_d;

    // Grant uses only the registered fill level: a same-cycle response never frees a slot.
    assign bank_req_o = arb_req_i & ~full;
    assign arb_gnt_o  = bank_gnt_i & ~full;
    assign push       = arb_req_i & bank_gnt_i & ~full;
    assign pop        = bank_rvalid_i & ~empty;

    tcdm_idx_fifo #(
        .Depth (MaxOut),
        .Width (IdxW),
        .CntW  (CntW)
    ) i_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (arb_idx_i),
        .pop_i   (pop),
        .rdata_o (head_idx),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    // Out-of-range head indices simply match no bit.
    always_comb begin
        rvalid_c = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            rvalid_c[i] = pop && (head_idx == IdxW'(i));
        end
    end

    assign err_d = err_q | (bank_rvalid_i & empty);
    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    if (RegResp) begin : g_reg_resp
        logic [NumReq-1:0]    rvalid_q;
        logic [DataWidth-1:0] rdata_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= '0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_c;
                if (pop) begin
                    rdata_q <= bank_rdata_i;
                end
            end
        end

        assign rvalid_o = rvalid_q;
        assign rdata_o  = rdata_q;
    end else begin : g_comb_resp
        assign rvalid_o = rvalid_c;
        assign rdata_o  = bank_rdata_i;
    end

endmodule
